// File: rtl/lcd_cmd_arbiter_if.sv
// Handshake bundle between the two LCD command sources, the arbiter and the
// LCD instruction transmitter. The arbiter takes the slave view; the sources
// and transmitter (or a bench standing in for them) take the master view.
interface lcd_cmd_arbiter_if;
  logic       req0;
  logic [9:0] db0;
  logic       req1;
  logic [9:0] db1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic       tx_start;
  logic [9:0] tx_db;
  logic       tx_done;
  logic       busy;

  modport master (
    output req0, db0, req1, db1, tx_done,
    input  gnt0, gnt1, done0, done1, tx_start, tx_db, busy
  );

  modport slave (
    input  req0, db0, req1, db1, tx_done,
    output gnt0, gnt1, done0, done1, tx_start, tx_db, busy
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Two-source arbiter for the LCD instruction transmitter. Grants one source
// at a time (round-robin when both ask), launches its {RS,RW,DB} word, waits
// for the bus cycle to finish and then for the HD44780 execution time before
// pulsing done to the owner. All outputs are registered.
module lcd_cmd_arbiter #(
  parameter int WAIT_CMD  = 2000,
  parameter int WAIT_LONG = 82000,
  parameter int CNT_W     = 17
) (
  input logic              clk,
  input logic              reset,
  lcd_cmd_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XMIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Terminal counts: the counter starts at zero on the cycle after tx_done.
  localparam logic [CNT_W-1:0] LIM_CMD_M1  = CNT_W'(WAIT_CMD - 1);
  localparam logic [CNT_W-1:0] LIM_LONG_M1 = CNT_W'(WAIT_LONG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q;
  logic             rr_q;        // source favoured when both request
  logic             owner_q;     // source that owns the in-flight command
  logic             long_q;      // in-flight command needs the long wait
  logic [CNT_W-1:0] cnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;
  logic             tx_start_q;
  logic [9:0]       tx_db_q;
  logic             busy_q;

  logic             grant_req_d;
  logic             grant_src_d;
  logic             long_cmd_d;
  logic             hold_end_d;

  // Arbitration decision, long-wait classification and wait-expiry detection.
  always_comb begin
    grant_req_d = 1'b0;
    grant_src_d = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_req_d = 1'b1;
      grant_src_d = rr_q;
    end else if (bus.req0) begin
      grant_req_d = 1'b1;
      grant_src_d = 1'b0;
    end else if (bus.req1) begin
      grant_req_d = 1'b1;
      grant_src_d = 1'b1;
    end else begin
      grant_req_d = 1'b0;
      grant_src_d = 1'b0;
    end

    // Clear Display (0x001) and Return Home (0x002/0x003) execute slowly.
    long_cmd_d = (tx_db_q[9:1] == 9'd0) || (tx_db_q[9:1] == 9'd1);

    if (long_q) begin
      hold_end_d = (cnt_q == LIM_LONG_M1);
    end else begin
      hold_end_d = (cnt_q == LIM_CMD_M1);
    end
  end

  // Command sequencer: grant, launch, wait for bus, wait for execution, done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      long_q     <= 1'b0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_db_q    <= 10'h000;
      busy_q     <= 1'b0;
    end else begin
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_req_d) begin
            state_q <= ST_ISSUE;
            busy_q  <= 1'b1;
            owner_q <= grant_src_d;
            rr_q    <= ~grant_src_d;
            tx_db_q <= grant_src_d ? bus.db1 : bus.db0;
            gnt0_q  <= ~grant_src_d;
            gnt1_q  <= grant_src_d;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // tx_done is deliberately not looked at here.
          tx_start_q <= 1'b1;
          busy_q     <= 1'b1;
          state_q    <= ST_XMIT;
        end
        ST_XMIT: begin
          busy_q <= 1'b1;
          if (bus.tx_done) begin
            cnt_q   <= '0;
            long_q  <= long_cmd_d;
            state_q <= ST_HOLD;
          end else begin
            state_q <= ST_XMIT;
          end
        end
        ST_HOLD: begin
          if (hold_end_d) begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            busy_q  <= 1'b1;
            cnt_q   <= cnt_q + CNT_ONE;
            state_q <= ST_HOLD;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_db    = tx_db_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter. A timestamp-based transaction model
// predicts every output on every cycle; literal timing checks pin the model.
module tb_lcd_cmd_arbiter;
  localparam int WC   = 150;
  localparam int WL   = 300;
  localparam int NONE = 32'h7fffffff;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   n_gnt1;
  int   n_done0;

  lcd_cmd_arbiter_if bus ();

  lcd_cmd_arbiter #(.WAIT_CMD(WC), .WAIT_LONG(WL), .CNT_W(17)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // model state: one in-flight transaction described by its event cycles
  logic       m_active;
  logic       m_owner;
  logic       m_ptr;
  logic       m_long;
  logic [9:0] m_word;
  logic [9:0] m_db_prev;
  int         m_gnt_cyc;
  int         m_start_cyc;
  int         m_done_cyc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // per-cycle compare against the model, then advance the model with this cycle's inputs
  initial begin
    logic [15:0] act;
    logic [15:0] exp;
    logic        e_busy;
    logic [9:0]  e_db;
    logic        src;
    m_active = 1'b0; m_ptr = 1'b0; m_db_prev = 10'h000; m_owner = 1'b0;
    m_long = 1'b0; m_word = 10'h000;
    m_gnt_cyc = NONE; m_start_cyc = NONE; m_done_cyc = NONE;
    forever begin
      @(negedge clk);
      e_busy = m_active && (cyc >= m_gnt_cyc) && (cyc < m_done_cyc);
      e_db   = (m_active && cyc >= m_gnt_cyc) ? m_word : m_db_prev;
      exp = {m_active && cyc == m_gnt_cyc && !m_owner,
             m_active && cyc == m_gnt_cyc && m_owner,
             m_active && cyc == m_done_cyc && !m_owner,
             m_active && cyc == m_done_cyc && m_owner,
             m_active && cyc == m_start_cyc,
             e_busy, e_db};
      if (!reset) exp = 16'h0000;
      act = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.tx_start, bus.busy, bus.tx_db};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL cycle_cmp cyc=%0d actual={g0 g1 d0 d1 st busy db}=%b required=%b",
                 cyc, act, exp);
      end
      if (bus.gnt1)  n_gnt1++;
      if (bus.done0) n_done0++;

      if (!reset) begin
        m_active = 1'b0; m_ptr = 1'b0; m_db_prev = 10'h000;
        m_gnt_cyc = NONE; m_start_cyc = NONE; m_done_cyc = NONE;
      end else begin
        if (m_active && m_done_cyc == NONE && cyc >= m_start_cyc && bus.tx_done)
          m_done_cyc = cyc + (m_long ? WL : WC) + 1;
        if (m_active && cyc == m_done_cyc) begin
          m_active  = 1'b0;
          m_db_prev = m_word;
        end
        if (!m_active && (bus.req0 || bus.req1)) begin
          src = (bus.req0 && bus.req1) ? m_ptr : bus.req1;
          m_owner     = src;
          m_word      = src ? bus.db1 : bus.db0;
          m_long      = m_word inside {10'h000, 10'h001, 10'h002, 10'h003};
          m_ptr       = ~src;
          m_active    = 1'b1;
          m_gnt_cyc   = cyc + 1;
          m_start_cyc = cyc + 2;
          m_done_cyc  = NONE;
        end
      end
    end
  end

  function automatic logic ev(input int sel);
    case (sel)
      0:       return bus.gnt0;
      1:       return bus.gnt1;
      2:       return bus.done0;
      3:       return bus.done1;
      4:       return bus.tx_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // wait (bounded) for an output pulse; returns its cycle, ends one cycle later at posedge+1
  task automatic wait_ev(input int sel, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ev(sel)) begin
        at = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_timeout event=%0d actual=none required=pulse", sel);
    end
  endtask

  task automatic pulse_txdone();
    bus.tx_done = 1'b1;
    step(1);
    bus.tx_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
  endtask

  logic [9:0] t3_word [6] = '{10'h001, 10'h003, 10'h004, 10'h002, 10'h005, 10'h101};
  int         t3_lat  [6] = '{301, 301, 151, 301, 151, 151};

  initial begin
    int r, g, s, t, d, pd, nb;
    cyc = 0; checks = 0; errors = 0; n_gnt1 = 0; n_done0 = 0;
    reset = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.db0 = 10'h000; bus.db1 = 10'h000;
    bus.tx_done = 1'b0;
    step(3);
    chk("reset_outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.tx_start, bus.busy, bus.tx_db}, 0);

    // 1: single command from source 0
    reset = 1'b1; bus.req0 = 1'b1; bus.db0 = 10'h028; r = cyc;
    wait_ev(0, g);
    chk("t1_gnt0_lat", g - r, 1);
    bus.req0 = 1'b0;
    wait_ev(4, s);
    chk("t1_start_lat", s - r, 2);
    chk("t1_tx_db", bus.tx_db, 10'h028);
    step(2);
    chk("t1_txdone_cycle", cyc - r, 5);
    pulse_txdone();
    wait_ev(2, d);
    chk("t1_done0_lat", d - (r + 5), 151);
    chk("t1_busy_after", bus.busy, 0);

    // 2: strict alternation with both sources held
    do_reset();
    reset = 1'b1; bus.req0 = 1'b1; bus.req1 = 1'b1; bus.db0 = 10'h0A0; bus.db1 = 10'h2B1;
    pd = -1;
    for (int k = 0; k < 6; k++) begin
      wait_ev(k % 2, g);
      if (k > 0) chk("t2_gnt_gap", g - pd, 1);
      if (k == 5) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
      wait_ev(4, s);
      step(2);
      pulse_txdone();
      wait_ev(2 + (k % 2), pd);
    end

    // 3: long versus normal execution waits
    for (int k = 0; k < 6; k++) begin
      bus.req1 = 1'b1; bus.db1 = t3_word[k];
      wait_ev(1, g);
      bus.req1 = 1'b0; bus.db1 = 10'h3FF;
      wait_ev(4, s);
      step(3);
      t = cyc;
      pulse_txdone();
      wait_ev(3, d);
      chk("t3_done1_lat", d - t, t3_lat[k]);
    end

    // 4: tx_done during ISSUE and during HOLD is ignored
    bus.req0 = 1'b1; bus.db0 = 10'h030;
    step(1);
    chk("t4_gnt0_now", bus.gnt0, 1);
    bus.req0 = 1'b0; bus.tx_done = 1'b1;
    step(1);
    bus.tx_done = 1'b0;
    step(3);
    t = cyc;
    pulse_txdone();
    step(5);
    pulse_txdone();
    step(40);
    pulse_txdone();
    wait_ev(2, d);
    chk("t4_done0_lat", d - t, 151);

    // 5: reset in the middle of HOLD
    bus.req0 = 1'b1; bus.db0 = 10'h038;
    wait_ev(0, g);
    bus.req0 = 1'b0;
    wait_ev(4, s);
    pulse_txdone();
    step(100);
    bus.req1 = 1'b1; bus.db1 = 10'h0C5;
    nb = n_done0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("t5_rst_outputs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.tx_start, bus.busy, bus.tx_db}, 0);
    step(2);
    reset = 1'b1; r = cyc;
    wait_ev(1, g);
    chk("t5_gnt1_lat", g - r, 1);
    bus.req1 = 1'b0;
    wait_ev(4, s);
    step(1);
    t = cyc;
    pulse_txdone();
    wait_ev(3, d);
    chk("t5_done1_lat", d - t, 151);
    chk("t5_no_done0", n_done0 - nb, 0);

    // 6: short req1 while busy is lost, held req1 is served right after done
    bus.req0 = 1'b1; bus.db0 = 10'h0E0;
    wait_ev(0, g);
    bus.req0 = 1'b0;
    wait_ev(4, s);
    nb = n_gnt1;
    bus.req1 = 1'b1; bus.db1 = 10'h0F0;
    step(1);
    bus.req1 = 1'b0;
    pulse_txdone();
    wait_ev(2, d);
    step(10);
    chk("t6_no_gnt1", n_gnt1 - nb, 0);
    bus.req0 = 1'b1; bus.db0 = 10'h0E4;
    wait_ev(0, g);
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.db1 = 10'h0F1;
    wait_ev(4, s);
    step(1);
    pulse_txdone();
    wait_ev(2, d);
    wait_ev(1, g);
    chk("t6_gnt1_after_done", g - d, 1);
    bus.req1 = 1'b0;
    wait_ev(4, s);
    pulse_txdone();
    wait_ev(3, d);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
